reorder_buffer: RTL and testbench
=================================

REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 SHALL have parameter ROB_DEPTH, default 16, number of entries (power of two, >= 4).
REQ-002 SHALL have parameter ROB_ADDR_WIDTH, default 4, log2(ROB_DEPTH).
REQ-003 SHALL have ports, one per line (name  direction  width  meaning):
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- flush  in  1  discard all entries.
- alloc_en  in  1  ID/ROB stage presents an instruction.
- alloc_reg_write_en  in  1  instruction writes a GPR.
- alloc_reg_write_addr  in  `RF_ADDR_BUS_WIDTH  destination register.
- alloc_exception_type  in  `EXC_TYPE_BUS_WIDTH  exception flags raised at decode.
- alloc_is_delayslot  in  1  instruction is in a delay slot.
- alloc_pc  in  `ADDR_BUS_WIDTH  instruction PC.
- alloc_ready  out  1  buffer not full.
- alloc_id  out  ROB_ADDR_WIDTH  index the next allocation will occupy (tail).
- wb_en  in  1  execution result valid.
- wb_id  in  ROB_ADDR_WIDTH  target entry.
- wb_data  in  `DATA_BUS_WIDTH  result.
- wb_exception_type  in  `EXC_TYPE_BUS_WIDTH  exception flags raised at execute.
- read_id_1, read_id_2  in  ROB_ADDR_WIDTH  operand reference lookup.
- read_ready_1, read_ready_2  out  1  referenced result available.
- read_data_1, read_data_2  out  `DATA_BUS_WIDTH  referenced result.
- commit_valid  out  1  head entry complete.
- commit_ready  in  1  retire stage accepts head.
- commit_id  out  ROB_ADDR_WIDTH  head index.
- commit_reg_write_en, commit_reg_write_addr, commit_data, commit_exception_type, commit_is_delayslot, commit_pc  out  widths as alloc_*/wb_*  head entry fields.
- rob_empty, rob_full  out  1  occupancy status.

Function
REQ-004 SHALL keep head and tail pointers of ROB_ADDR_WIDTH+1 bits (extra wrap bit); empty = pointers equal; full = indices equal, wrap bits differ.
REQ-005 Allocation SHALL occur when alloc_en && alloc_ready: entry[tail] written, busy=1, done=0, data=0, tail+1 (mod 2^(ROB_ADDR_WIDTH+1)).
REQ-006 alloc_ready SHALL equal !rob_full from registered state; no same-cycle bypass of a commit freeing space.
REQ-007 Writeback SHALL set done=1, data=wb_data, exception = stored OR wb_exception_type, only when wb_en and entry[wb_id].busy; otherwise ignored.
REQ-008 commit_valid SHALL be !rob_empty && done[head], from registered state (writeback to head visible next cycle).
REQ-009 Commit SHALL occur when commit_valid && commit_ready: busy=0, done=0, head+1.
REQ-010 commit_* data outputs SHALL be combinational reads of entry[head]; commit_id = head index.
REQ-011 Allocate, writeback, and commit SHALL all complete in the same cycle when enabled, on distinct entries.
REQ-012 read_ready_n SHALL be 1 when entry[read_id_n] is busy and (done, or wb_en && wb_id==read_id_n); read_data_n SHALL be the wb_data bypass in the latter case, else stored data; read_ready_n=0, read_data_n=0 for non-busy entries.
REQ-013 Pointers SHALL wrap from ROB_DEPTH-1 to 0 with wrap bit toggling.
REQ-014 flush SHALL, on the next edge, clear all busy/done bits and set head=tail=0; alloc, wb, and commit in that cycle SHALL be discarded.
REQ-015 rst SHALL take priority over flush; flush SHALL take priority over all other operations.

Reset
REQ-016 After rst: head=tail=0, all busy/done/data/exception/pc/reg fields 0; rob_empty=1, rob_full=0, alloc_ready=1, alloc_id=0, commit_valid=0, all commit_*, read_ready_*, and read_data_* outputs 0.
REQ-017 rst asserted mid-operation SHALL discard all entries identically to REQ-016, regardless of other inputs.

Verification
REQ-018 Alloc pc=0x100, rd=5; wb_id=0, data=0xDEADBEEF next cycle -> commit_valid=1 one cycle after wb; commit_pc=0x100, commit_data=0xDEADBEEF, commit_reg_write_addr=5.
REQ-019 Allocate 16 with no commit -> rob_full=1, alloc_ready=0, 17th alloc_en ignored (tail unchanged); commit one -> alloc_ready=1 next cycle.
REQ-020 Writeback out of order to ids 2,1,0 -> commit order strictly 0,1,2; commit_valid held 0 until id 0 is done.
REQ-021 read_id_1=3 with wb_en, wb_id=3, data=0x55 same cycle -> read_ready_1=1, read_data_1=0x55 combinationally; wb to non-busy id 7 -> no state change.
REQ-022 Run pointers past 2*ROB_DEPTH allocations/commits -> correct wrap, empty/full flags never spurious.
REQ-023 flush with 5 busy entries plus simultaneous alloc/commit -> next cycle rob_empty=1, alloc_id=0, commit_valid=0.

Source files
------------

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: allocates entries in program order, accepts out-of-order
// writeback with operand bypass, and retires completed entries in order from the head.

`ifndef RF_ADDR_BUS_WIDTH
`define RF_ADDR_BUS_WIDTH 5
`endif
`ifndef EXC_TYPE_BUS_WIDTH
`define EXC_TYPE_BUS_WIDTH 8
`endif
`ifndef ADDR_BUS_WIDTH
`define ADDR_BUS_WIDTH 32
`endif
`ifndef DATA_BUS_WIDTH
`define DATA_BUS_WIDTH 32
`endif

module reorder_buffer #(
    parameter int ROB_DEPTH      = 16,
    parameter int ROB_ADDR_WIDTH = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            flush,

    input  logic                            alloc_en,
    input  logic                            alloc_reg_write_en,
    input  logic [`RF_ADDR_BUS_WIDTH-1:0]   alloc_reg_write_addr,
    input  logic [`EXC_TYPE_BUS_WIDTH-1:0]  alloc_exception_type,
    input  logic                            alloc_is_delayslot,
    input  logic [`ADDR_BUS_WIDTH-1:0]      alloc_pc,
    output logic                            alloc_ready,
    output logic [ROB_ADDR_WIDTH-1:0]       alloc_id,

    input  logic                            wb_en,
    input  logic [ROB_ADDR_WIDTH-1:0]       wb_id,
    input  logic [`DATA_BUS_WIDTH-1:0]      wb_data,
    input  logic [`EXC_TYPE_BUS_WIDTH-1:0]  wb_exception_type,

    input  logic [ROB_ADDR_WIDTH-1:0]       read_id_1,
    output logic                            read_ready_1,
    output logic [`DATA_BUS_WIDTH-1:0]      read_data_1,
    input  logic [ROB_ADDR_WIDTH-1:0]       read_id_2,
    output logic                            read_ready_2,
    output logic [`DATA_BUS_WIDTH-1:0]      read_data_2,

    output logic                            commit_valid,
    input  logic                            commit_ready,
    output logic [ROB_ADDR_WIDTH-1:0]       commit_id,
    output logic                            commit_reg_write_en,
    output logic [`RF_ADDR_BUS_WIDTH-1:0]   commit_reg_write_addr,
    output logic [`DATA_BUS_WIDTH-1:0]      commit_data,
    output logic [`EXC_TYPE_BUS_WIDTH-1:0]  commit_exception_type,
    output logic                            commit_is_delayslot,
    output logic [`ADDR_BUS_WIDTH-1:0]      commit_pc,

    output logic                            rob_empty,
    output logic                            rob_full
);

    localparam logic [ROB_ADDR_WIDTH:0] PTR_ONE = {{ROB_ADDR_WIDTH{1'b0}}, 1'b1};

    logic [ROB_ADDR_WIDTH:0]            head_q, head_d;
    logic [ROB_ADDR_WIDTH:0]            tail_q, tail_d;
    logic [ROB_DEPTH-1:0]               busy_q, busy_d;
    logic [ROB_DEPTH-1:0]               done_q, done_d;
    logic [`DATA_BUS_WIDTH-1:0]         data_q     [ROB_DEPTH];
    logic [`DATA_BUS_WIDTH-1:0]         data_d     [ROB_DEPTH];
    logic [`EXC_TYPE_BUS_WIDTH-1:0]     exc_q      [ROB_DEPTH];
    logic [`EXC_TYPE_BUS_WIDTH-1:0]     exc_d      [ROB_DEPTH];
    logic [`ADDR_BUS_WIDTH-1:0]         pc_q       [ROB_DEPTH];
    logic [`ADDR_BUS_WIDTH-1:0]         pc_d       [ROB_DEPTH];
    logic [`RF_ADDR_BUS_WIDTH-1:0]      reg_addr_q [ROB_DEPTH];
    logic [`RF_ADDR_BUS_WIDTH-1:0]      reg_addr_d [ROB_DEPTH];
    logic [ROB_DEPTH-1:0]               reg_we_q, reg_we_d;
    logic [ROB_DEPTH-1:0]               dslot_q, dslot_d;

    logic [ROB_ADDR_WIDTH-1:0]          head_idx;
    logic [ROB_ADDR_WIDTH-1:0]          tail_idx;
    logic                               alloc_fire;
    logic                               wb_fire;
    logic                               commit_fire;

    // Occupancy comes purely from registered pointers, so a retiring head never
    // frees space for an allocation in the same cycle.
    always_comb begin
        head_idx     = head_q[ROB_ADDR_WIDTH-1:0];
        tail_idx     = tail_q[ROB_ADDR_WIDTH-1:0];
        rob_empty    = (head_q == tail_q);
        rob_full     = (head_idx == tail_idx) && (head_q[ROB_ADDR_WIDTH] != tail_q[ROB_ADDR_WIDTH]);
        alloc_ready  = !rob_full;
        alloc_id     = tail_idx;
        commit_valid = !rob_empty && done_q[head_idx];
        commit_id    = head_idx;
        alloc_fire   = alloc_en && alloc_ready;
        wb_fire      = wb_en && busy_q[wb_id];
        commit_fire  = commit_valid && commit_ready;
    end

    always_comb begin
        commit_reg_write_en   = reg_we_q[head_idx];
        commit_reg_write_addr = reg_addr_q[head_idx];
        commit_data           = data_q[head_idx];
        commit_exception_type = exc_q[head_idx];
        commit_is_delayslot   = dslot_q[head_idx];
        commit_pc             = pc_q[head_idx];
    end

    // Operand lookup: a writeback landing this cycle is forwarded ahead of stored data.
    always_comb begin
        read_ready_1 = 1'b0;
        read_data_1  = '0;
        if (busy_q[read_id_1]) begin
            if (wb_en && (wb_id == read_id_1)) begin
                read_ready_1 = 1'b1;
                read_data_1  = wb_data;
            end else if (done_q[read_id_1]) begin
                read_ready_1 = 1'b1;
                read_data_1  = data_q[read_id_1];
            end
        end
    end

    always_comb begin
        read_ready_2 = 1'b0;
        read_data_2  = '0;
        if (busy_q[read_id_2]) begin
            if (wb_en && (wb_id == read_id_2)) begin
                read_ready_2 = 1'b1;
                read_data_2  = wb_data;
            end else if (done_q[read_id_2]) begin
                read_ready_2 = 1'b1;
                read_data_2  = data_q[read_id_2];
            end
        end
    end

    // Next-state: flush wins over every other operation; otherwise wb, alloc and
    // commit act on distinct entries and are applied together.
    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        busy_d     = busy_q;
        done_d     = done_q;
        data_d     = data_q;
        exc_d      = exc_q;
        pc_d       = pc_q;
        reg_addr_d = reg_addr_q;
        reg_we_d   = reg_we_q;
        dslot_d    = dslot_q;

        if (flush) begin
            head_d = '0;
            tail_d = '0;
            busy_d = '0;
            done_d = '0;
        end else begin
            if (wb_fire) begin
                done_d[wb_id] = 1'b1;
                data_d[wb_id] = wb_data;
                exc_d[wb_id]  = exc_q[wb_id] | wb_exception_type;
            end
            if (alloc_fire) begin
                busy_d[tail_idx]     = 1'b1;
                done_d[tail_idx]     = 1'b0;
                data_d[tail_idx]     = '0;
                exc_d[tail_idx]      = alloc_exception_type;
                pc_d[tail_idx]       = alloc_pc;
                reg_addr_d[tail_idx] = alloc_reg_write_addr;
                reg_we_d[tail_idx]   = alloc_reg_write_en;
                dslot_d[tail_idx]    = alloc_is_delayslot;
                tail_d               = tail_q + PTR_ONE;
            end
            if (commit_fire) begin
                busy_d[head_idx] = 1'b0;
                done_d[head_idx] = 1'b0;
                head_d           = head_q + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q   <= '0;
            tail_q   <= '0;
            busy_q   <= '0;
            done_q   <= '0;
            reg_we_q <= '0;
            dslot_q  <= '0;
            for (int i = 0; i < ROB_DEPTH; i++) begin
                data_q[i]     <= '0;
                exc_q[i]      <= '0;
                pc_q[i]       <= '0;
                reg_addr_q[i] <= '0;
            end
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            reg_we_q   <= reg_we_d;
            dslot_q    <= dslot_d;
            data_q     <= data_d;
            exc_q      <= exc_d;
            pc_q       <= pc_d;
            reg_addr_q <= reg_addr_d;
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed self-checking bench for reorder_buffer: reset, basic flow, full/backpressure,
// in-order retirement, bypass, concurrent ops, flush, mid-run reset and pointer wrap.

`ifndef RF_ADDR_BUS_WIDTH
`define RF_ADDR_BUS_WIDTH 5
`endif
`ifndef EXC_TYPE_BUS_WIDTH
`define EXC_TYPE_BUS_WIDTH 8
`endif
`ifndef ADDR_BUS_WIDTH
`define ADDR_BUS_WIDTH 32
`endif
`ifndef DATA_BUS_WIDTH
`define DATA_BUS_WIDTH 32
`endif

module tb_reorder_buffer;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic                           clk = 1'b0;
    logic                           rst;
    logic                           flush;
    logic                           alloc_en;
    logic                           alloc_reg_write_en;
    logic [`RF_ADDR_BUS_WIDTH-1:0]  alloc_reg_write_addr;
    logic [`EXC_TYPE_BUS_WIDTH-1:0] alloc_exception_type;
    logic                           alloc_is_delayslot;
    logic [`ADDR_BUS_WIDTH-1:0]     alloc_pc;
    logic                           alloc_ready;
    logic [AW-1:0]                  alloc_id;
    logic                           wb_en;
    logic [AW-1:0]                  wb_id;
    logic [`DATA_BUS_WIDTH-1:0]     wb_data;
    logic [`EXC_TYPE_BUS_WIDTH-1:0] wb_exception_type;
    logic [AW-1:0]                  read_id_1, read_id_2;
    logic                           read_ready_1, read_ready_2;
    logic [`DATA_BUS_WIDTH-1:0]     read_data_1, read_data_2;
    logic                           commit_valid;
    logic                           commit_ready;
    logic [AW-1:0]                  commit_id;
    logic                           commit_reg_write_en;
    logic [`RF_ADDR_BUS_WIDTH-1:0]  commit_reg_write_addr;
    logic [`DATA_BUS_WIDTH-1:0]     commit_data;
    logic [`EXC_TYPE_BUS_WIDTH-1:0] commit_exception_type;
    logic                           commit_is_delayslot;
    logic [`ADDR_BUS_WIDTH-1:0]     commit_pc;
    logic                           rob_empty, rob_full;

    int checks   = 0;
    int failures = 0;
    logic [AW-1:0] exp_tail;

    reorder_buffer #(.ROB_DEPTH(DEPTH), .ROB_ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .alloc_en(alloc_en), .alloc_reg_write_en(alloc_reg_write_en),
        .alloc_reg_write_addr(alloc_reg_write_addr), .alloc_exception_type(alloc_exception_type),
        .alloc_is_delayslot(alloc_is_delayslot), .alloc_pc(alloc_pc),
        .alloc_ready(alloc_ready), .alloc_id(alloc_id),
        .wb_en(wb_en), .wb_id(wb_id), .wb_data(wb_data), .wb_exception_type(wb_exception_type),
        .read_id_1(read_id_1), .read_id_2(read_id_2),
        .read_ready_1(read_ready_1), .read_ready_2(read_ready_2),
        .read_data_1(read_data_1), .read_data_2(read_data_2),
        .commit_valid(commit_valid), .commit_ready(commit_ready), .commit_id(commit_id),
        .commit_reg_write_en(commit_reg_write_en), .commit_reg_write_addr(commit_reg_write_addr),
        .commit_data(commit_data), .commit_exception_type(commit_exception_type),
        .commit_is_delayslot(commit_is_delayslot), .commit_pc(commit_pc),
        .rob_empty(rob_empty), .rob_full(rob_full)
    );

    always #5 clk = ~clk;

    task checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Drives one cycle's worth of alloc/wb/commit requests; all other controls stay as set.
    task applyStimulus(input logic a_en, input logic [31:0] a_pc, input logic [4:0] a_rd,
                       input logic w_en, input logic [AW-1:0] w_id, input logic [31:0] w_data,
                       input logic c_rdy);
        alloc_en             = a_en;
        alloc_pc             = a_pc;
        alloc_reg_write_addr = a_rd;
        alloc_reg_write_en   = a_en;
        wb_en                = w_en;
        wb_id                = w_id;
        wb_data              = w_data;
        commit_ready         = c_rdy;
    endtask

    task step_clock;
        @(posedge clk);
        #1;
    endtask

    task idle;
        applyStimulus(1'b0, 32'h0, 5'd0, 1'b0, '0, 32'h0, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        alloc_exception_type = '0;
        alloc_is_delayslot = 1'b0;
        wb_exception_type = '0;
        read_id_1 = '0;
        read_id_2 = '0;
        idle();
        step_clock();
        step_clock();
        rst = 1'b0;
        #1;

        checkOutput("reset_empty", rob_empty, 1);
        checkOutput("reset_full", rob_full, 0);
        checkOutput("reset_alloc_ready", alloc_ready, 1);
        checkOutput("reset_alloc_id", alloc_id, 0);
        checkOutput("reset_commit_valid", commit_valid, 0);
        checkOutput("reset_commit_pc", commit_pc, 0);
        checkOutput("reset_commit_data", commit_data, 0);
        checkOutput("reset_read_ready", read_ready_1, 0);
        checkOutput("reset_read_data", read_data_1, 0);

        // Single instruction flow
        applyStimulus(1'b1, 32'h100, 5'd5, 1'b0, '0, 32'h0, 1'b0);
        step_clock();
        checkOutput("basic_alloc_id", alloc_id, 1);
        checkOutput("basic_not_empty", rob_empty, 0);
        checkOutput("basic_no_commit_yet", commit_valid, 0);
        applyStimulus(1'b0, 32'h0, 5'd0, 1'b1, 4'd0, 32'hDEADBEEF, 1'b0);
        read_id_1 = 4'd0;
        #1;
        checkOutput("basic_bypass_ready", read_ready_1, 1);
        checkOutput("basic_bypass_data", read_data_1, 32'hDEADBEEF);
        checkOutput("basic_commit_same_cycle", commit_valid, 0);
        step_clock();
        idle();
        #1;
        checkOutput("basic_commit_valid", commit_valid, 1);
        checkOutput("basic_commit_pc", commit_pc, 32'h100);
        checkOutput("basic_commit_data", commit_data, 32'hDEADBEEF);
        checkOutput("basic_commit_rd", commit_reg_write_addr, 5);
        checkOutput("basic_commit_we", commit_reg_write_en, 1);
        checkOutput("basic_commit_id", commit_id, 0);
        applyStimulus(1'b0, 32'h0, 5'd0, 1'b0, '0, 32'h0, 1'b1);
        step_clock();
        idle();
        #1;
        checkOutput("basic_empty_after", rob_empty, 1);
        checkOutput("basic_valid_after", commit_valid, 0);

        // Fill to full, check backpressure and no same-cycle bypass of a freed slot
        rst = 1'b1;
        step_clock();
        rst = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b1, 32'h1000 + 32'(i * 4), 5'(i), 1'b0, '0, 32'h0, 1'b0);
            step_clock();
        end
        idle();
        #1;
        checkOutput("full_flag", rob_full, 1);
        checkOutput("full_alloc_ready", alloc_ready, 0);
        checkOutput("full_alloc_id", alloc_id, 0);
        applyStimulus(1'b1, 32'h999, 5'd9, 1'b0, '0, 32'h0, 1'b0);
        step_clock();
        idle();
        #1;
        checkOutput("full_ignored_tail", alloc_id, 0);
        checkOutput("full_ignored_flag", rob_full, 1);
        checkOutput("full_ignored_pc", commit_pc, 32'h1000);
        applyStimulus(1'b0, 32'h0, 5'd0, 1'b1, 4'd0, 32'h11, 1'b0);
        step_clock();
        idle();
        #1;
        checkOutput("full_head_valid", commit_valid, 1);
        applyStimulus(1'b0, 32'h0, 5'd0, 1'b0, '0, 32'h0, 1'b1);
        #1;
        checkOutput("full_no_bypass", alloc_ready, 0);
        step_clock();
        idle();
        #1;
        checkOutput("full_freed_ready", alloc_ready, 1);
        checkOutput("full_freed_flag", rob_full, 0);
        checkOutput("full_freed_head", commit_id, 1);

        // Reset mid-run overrides concurrent requests
        rst = 1'b1;
        applyStimulus(1'b1, 32'h777, 5'd7, 1'b1, 4'd1, 32'h22, 1'b1);
        step_clock();
        rst = 1'b0;
        idle();
        #1;
        checkOutput("midrst_empty", rob_empty, 1);
        checkOutput("midrst_full", rob_full, 0);
        checkOutput("midrst_alloc_id", alloc_id, 0);
        checkOutput("midrst_commit_valid", commit_valid, 0);
        checkOutput("midrst_commit_data", commit_data, 0);

        // Out-of-order writeback, in-order retirement
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 32'h200 + 32'(i * 4), 5'(i + 1), 1'b0, '0, 32'h0, 1'b0);
            step_clock();
        end
        applyStimulus(1'b0, 32'h0, 5'd0, 1'b1, 4'd2, 32'hC2, 1'b0);
        step_clock();
        idle();
        #1;
        checkOutput("ooo_wait_after_2", commit_valid, 0);
        applyStimulus(1'b0, 32'h0, 5'd0, 1'b1, 4'd1, 32'hC1, 1'b0);
        step_clock();
        idle();
        #1;
        checkOutput("ooo_wait_after_1", commit_valid, 0);
        applyStimulus(1'b0, 32'h0, 5'd0, 1'b1, 4'd0, 32'hC0, 1'b0);
        step_clock();
        applyStimulus(1'b0, 32'h0, 5'd0, 1'b0, '0, 32'h0, 1'b1);
        #1;
        checkOutput("ooo_c0_valid", commit_valid, 1);
        checkOutput("ooo_c0_id", commit_id, 0);
        checkOutput("ooo_c0_data", commit_data, 32'hC0);
        step_clock();
        checkOutput("ooo_c1_valid", commit_valid, 1);
        checkOutput("ooo_c1_id", commit_id, 1);
        checkOutput("ooo_c1_data", commit_data, 32'hC1);
        checkOutput("ooo_c1_pc", commit_pc, 32'h204);
        step_clock();
        checkOutput("ooo_c2_id", commit_id, 2);
        checkOutput("ooo_c2_data", commit_data, 32'hC2);
        step_clock();
        idle();
        #1;
        checkOutput("ooo_drained", rob_empty, 1);

        // Bypass on a busy entry, writeback to a non-busy entry ignored
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 32'h300 + 32'(i * 4), 5'(i), 1'b0, '0, 32'h0, 1'b0);
            step_clock();
        end
        applyStimulus(1'b0, 32'h0, 5'd0, 1'b1, 4'd3, 32'h55, 1'b0);
        read_id_1 = 4'd3;
        read_id_2 = 4'd4;
        #1;
        checkOutput("byp_ready_1", read_ready_1, 1);
        checkOutput("byp_data_1", read_data_1, 32'h55);
        checkOutput("byp_pending_ready_2", read_ready_2, 0);
        checkOutput("byp_pending_data_2", read_data_2, 0);
        step_clock();
        applyStimulus(1'b0, 32'h0, 5'd0, 1'b1, 4'd7, 32'h77, 1'b0);
        read_id_2 = 4'd7;
        #1;
        checkOutput("nonbusy_ready_2", read_ready_2, 0);
        checkOutput("nonbusy_data_2", read_data_2, 0);
        step_clock();
        applyStimulus(1'b1, 32'h310, 5'd4, 1'b0, '0, 32'h0, 1'b0);
        step_clock();
        idle();
        #1;
        checkOutput("nonbusy_not_done", read_ready_2, 0);
        checkOutput("stored_ready_1", read_ready_1, 1);
        checkOutput("stored_data_1", read_data_1, 32'h55);

        // Alloc, writeback and commit together
        applyStimulus(1'b1, 32'h314, 5'd5, 1'b1, 4'd4, 32'h44, 1'b1);
        step_clock();
        idle();
        #1;
        checkOutput("conc_alloc_id", alloc_id, 9);
        checkOutput("conc_commit_id", commit_id, 4);
        checkOutput("conc_commit_valid", commit_valid, 1);
        checkOutput("conc_commit_data", commit_data, 32'h44);

        // Flush with five busy entries and concurrent requests
        flush = 1'b1;
        applyStimulus(1'b1, 32'h318, 5'd6, 1'b1, 4'd5, 32'h66, 1'b1);
        read_id_1 = 4'd4;
        step_clock();
        flush = 1'b0;
        idle();
        #1;
        checkOutput("flush_empty", rob_empty, 1);
        checkOutput("flush_alloc_id", alloc_id, 0);
        checkOutput("flush_commit_valid", commit_valid, 0);
        checkOutput("flush_full", rob_full, 0);
        checkOutput("flush_read_ready", read_ready_1, 0);

        // Pointer wrap over more than two full laps
        exp_tail = '0;
        for (int k = 0; k < 2 * DEPTH + 5; k++) begin
            applyStimulus(1'b1, 32'h4000 + 32'(k), 5'd1, 1'b0, '0, 32'h0, 1'b0);
            step_clock();
            applyStimulus(1'b0, 32'h0, 5'd0, 1'b1, exp_tail, 32'(k), 1'b0);
            step_clock();
            applyStimulus(1'b0, 32'h0, 5'd0, 1'b0, '0, 32'h0, 1'b1);
            #1;
            checkOutput("wrap_commit_pc", commit_pc, 32'h4000 + 32'(k));
            checkOutput("wrap_commit_data", commit_data, 32'(k));
            step_clock();
            idle();
            #1;
            exp_tail = exp_tail + 1'b1;
            checkOutput("wrap_empty", rob_empty, 1);
            checkOutput("wrap_not_full", rob_full, 0);
            checkOutput("wrap_alloc_id", alloc_id, exp_tail);
        end
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b1, 32'h5000, 5'd2, 1'b0, '0, 32'h0, 1'b0);
            step_clock();
        end
        idle();
        #1;
        checkOutput("wrap_fill_full", rob_full, 1);
        checkOutput("wrap_fill_not_empty", rob_empty, 0);
        checkOutput("wrap_fill_alloc_id", alloc_id, 5);
        checkOutput("wrap_fill_head", commit_id, 5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
